// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the MIPS data memory controller
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // Size code 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian lane select/extend for loads and lane merge for stores
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  boff_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;

  assign shifted = rword_i >> {boff_i, 3'b000};
  assign half    = boff_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    load_o = rword_i;
    case (size_i)
      SIZE_BYTE: load_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_o = {{16{~unsigned_i & half[15]}}, half};
      default:   load_o = rword_i;
    endcase
  end

  always_comb begin
    lane_data = wdata_i;
    lane_mask = 4'b1111;
    case (size_i)
      SIZE_BYTE: begin
        lane_data = {4{wdata_i[7:0]}};
        lane_mask = 4'b0001 << boff_i;
      end
      SIZE_HALF: begin
        lane_data = {2{wdata_i[15:0]}};
        lane_mask = boff_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = wdata_i;
        lane_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    store_o = rword_i;
    for (int n = 0; n < 4; n++) begin
      if (lane_mask[n]) store_o[8*n +: 8] = lane_data[8*n +: 8];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - MEM-stage data memory with wait states and misalignment rejection
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int WAIT_CYCLES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wrData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        misaligned
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  dmem_state_t    state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW+1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic           write_q, write_d;
  logic           mis_q, mis_d;
  logic [31:0]    rdata_q;
  logic [31:0]    mem_q [DEPTH];

  logic           commit;
  logic [31:0]    load_word, store_word;
  logic           unused_addr;

  assign unused_addr = ^address[31:IW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = address[IW+1:0];
          wdata_d = wrData;
          size_d  = memSize;
          uns_d   = memUnsigned;
          write_d = MemWrite;
          mis_d   = is_misaligned(memSize, address[1:0]);
          if (mis_d || WAIT_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The "next" request fields describe the access being committed, whether it
  // was just accepted from IDLE (no wait states) or is leaving BUSY.
  assign commit = (state_d == DONE) && (state_q != DONE) && !mis_d;

  dmem_lane_align u_align (
    .rword_i    (mem_q[addr_d[IW+1:2]]),
    .wdata_i    (wdata_d),
    .size_i     (size_d),
    .boff_i     (addr_d[1:0]),
    .unsigned_i (uns_d),
    .load_o     (load_word),
    .store_o    (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      mis_q   <= mis_d;
      if (commit && !write_d) rdata_q <= load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end
    end else if (commit && write_d) begin
      mem_q[addr_d[IW+1:2]] <= store_word;
    end
  end

  assign readData   = rdata_q;
  assign memReady   = (state_q == DONE);
  assign misaligned = (state_q == DONE) && mis_q;

endmodule
